dwc_lane_tx: RTL and testbench

- CPU-side transmitter for one lane (A or B) of the duplicate-with-compare checker.
- Buffers words pushed by the CPU and presents each word to the comparator using the data_set / interrupt / ready handshake.
- Releases the word once the comparator acknowledges it, and tracks compare results, mismatches and handshake timeouts.
- Two instances are used: one per CPU, one per comparator lane.

---
 rtl/dwc_lane_tx_if.sv | 24 ++
 rtl/dwc_lane_tx.sv | 124 ++++++++++++
 tb/tb_dwc_lane_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dwc_lane_tx_if.sv
// Handshake bundle for one dwc_lane_tx: CPU push port plus the comparator lane link.
interface dwc_lane_tx_if #(
  parameter int DATA_W = 32
) ();
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              data_set;
  logic [DATA_W-1:0] data_out;
  logic              cmp_irq;
  logic              cmp_ready;
  logic              cmp_match;

  // master: the lane transmitter; slave: CPU/comparator environment
  modport master (
    input  wr_valid, wr_data, cmp_irq, cmp_ready, cmp_match,
    output wr_ready, data_set, data_out
  );

  modport slave (
    output wr_valid, wr_data, cmp_irq, cmp_ready, cmp_match,
    input  wr_ready, data_set, data_out
  );
endinterface

// File: rtl/dwc_lane_tx.sv
// Lane transmitter for the duplicate-with-compare checker: push buffer + data_set/irq/ready handshake.
// Optional fault injection on the presented word is enabled by defining FAULT_INJECT_EN.
module dwc_lane_tx #(
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  dwc_lane_tx_if.master     bus,
  output logic              busy,
  output logic              last_match,
  output logic [15:0]       mismatch_cnt,
  output logic              timeout_err,
  input  logic              inject_en,
  input  logic [DATA_W-1:0] lfsr_mask
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SET, RELEASE, ERROR} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       rd_ptr, wr_ptr;
  logic              full, empty, push, pop, srst, timed_out;
  logic [CW-1:0]     wait_cnt;
  logic [DATA_W-1:0] head, load_word;
  logic [15:0]       mis_cnt_q;

  assign srst  = rst | clear;
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign push  = bus.wr_valid & ~full;
  assign head  = mem[rd_ptr[AW-1:0]];
  assign timed_out = (wait_cnt == CNT_LAST);

  assign bus.wr_ready = ~full;
  assign busy         = (state != IDLE) | ~empty;
  assign mismatch_cnt = mis_cnt_q;

`ifdef FAULT_INJECT_EN
  assign load_word = inject_en ? (head ^ lfsr_mask) : head;
`else
  assign load_word = head;
  logic unused_fi;
  assign unused_fi = ^{inject_en, lfsr_mask};
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_n;
  end

  // The head word stays buffered until the comparator releases it or the wait times out.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE:    if (!empty) state_n = LOAD;
      LOAD:    state_n = SET;
      SET: begin
        if (bus.cmp_irq) begin
          state_n = RELEASE;
        end else if (timed_out) begin
          state_n = ERROR;
          pop     = 1'b1;
        end
      end
      RELEASE: begin
        if (bus.cmp_ready || timed_out) begin
          state_n = bus.cmp_ready ? IDLE : ERROR;
          pop     = 1'b1;
        end
      end
      ERROR:   state_n = ERROR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wait_cnt <= '0;
    end else if (state_n != state) begin
      wait_cnt <= '0;
    end else if (state == SET || state == RELEASE) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      bus.data_set <= 1'b0;
      bus.data_out <= '0;
      last_match   <= 1'b0;
      mis_cnt_q    <= '0;
      timeout_err  <= 1'b0;
    end else begin
      bus.data_set <= (state_n == SET);
      if (state == LOAD) bus.data_out <= load_word;
      if (state == SET && bus.cmp_irq) begin
        last_match <= bus.cmp_match;
        if (!bus.cmp_match && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 16'd1;
      end
      if (state_n == ERROR) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dwc_lane_tx.sv
// Self-checking bench for dwc_lane_tx: directed cases plus randomized traffic against a queue model.
module tb_dwc_lane_tx;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst, clear, inject_en;
  logic [DW-1:0] lfsr_mask;
  logic          busy, last_match, timeout_err;
  logic [15:0]   mismatch_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_q[$];
  logic [15:0]   model_mis;
  logic          model_last;

  dwc_lane_tx_if #(.DATA_W(DW)) bus ();

  dwc_lane_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus),
    .busy(busy), .last_match(last_match), .mismatch_cnt(mismatch_cnt),
    .timeout_err(timeout_err), .inject_en(inject_en), .lfsr_mask(lfsr_mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_mis  = 16'd0;
    model_last = 1'b0;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_data_set"},   32'(bus.data_set),   32'd0);
    chk({t, "_data_out"},   32'(bus.data_out),   32'd0);
    chk({t, "_wr_ready"},   32'(bus.wr_ready),   32'd1);
    chk({t, "_busy"},       32'(busy),           32'd0);
    chk({t, "_last_match"}, 32'(last_match),     32'd0);
    chk({t, "_mismatch"},   32'(mismatch_cnt),   32'd0);
    chk({t, "_timeout"},    32'(timeout_err),    32'd0);
  endtask

  task automatic push(input logic [31:0] w);
    bit acc;
    acc = (model_q.size() < DEPTH);
    chk("wr_ready", 32'(bus.wr_ready), 32'(acc));
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    step();
    bus.wr_valid = 1'b0;
    if (acc) model_q.push_back(w);
  endtask

  task automatic wait_set();
    int n;
    n = 0;
    while (bus.data_set !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("wait_data_set", 32'(bus.data_set), 32'd1);
  endtask

  task automatic xfer(input logic match, input int irq_dly, input int rdy_dly);
    logic [31:0] exp_w;
    wait_set();
    exp_w = (model_q.size() > 0) ? model_q[0] : 32'hxxxx_xxxx;
    chk("data_out_order", bus.data_out, exp_w);
    repeat (irq_dly) begin
      bus.cmp_ready = 1'($urandom_range(0, 1));
      step();
      chk("set_hold_data_set", 32'(bus.data_set), 32'd1);
      chk("set_hold_data_out", bus.data_out, exp_w);
    end
    bus.cmp_ready = 1'b0;
    bus.cmp_irq   = 1'b1;
    bus.cmp_match = match;
    step();
    bus.cmp_irq   = 1'b0;
    bus.cmp_match = 1'b0;
    model_last = match;
    if (!match && model_mis != 16'hFFFF) model_mis++;
    chk("data_set_drop", 32'(bus.data_set), 32'd0);
    repeat (rdy_dly) begin
      bus.cmp_irq = 1'($urandom_range(0, 1));
      step();
      chk("release_hold", 32'(bus.data_set), 32'd0);
    end
    bus.cmp_irq   = 1'b0;
    bus.cmp_ready = 1'b1;
    step();
    bus.cmp_ready = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    chk("last_match",   32'(last_match),   32'(model_last));
    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(model_mis));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; inject_en = 1'b0; lfsr_mask = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    bus.cmp_irq = 1'b0; bus.cmp_ready = 1'b0; bus.cmp_match = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b0;
    chk_reset("reset");

    // Single word: 2-cycle latency, then full handshake.
    push(32'hDEADBEEF);
    chk("lat_cycle0", 32'(bus.data_set), 32'd0);
    step();
    chk("lat_cycle1", 32'(bus.data_set), 32'd0);
    step();
    chk("lat_cycle2", 32'(bus.data_set), 32'd1);
    chk("lat_data", bus.data_out, 32'hDEADBEEF);
    xfer(1'b1, 0, 0);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_last", 32'(last_match), 32'd1);

    // Overfill: fifth push dropped, four words delivered in order.
    for (int i = 0; i < 5; i++) push(32'h1000_0000 + 32'(i));
    chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("full_depth", 32'(model_q.size()), 32'(DEPTH));
    for (int i = 0; i < 4; i++) xfer(1'b1, 1, 1);
    chk("full_drained_busy", 32'(busy), 32'd0);

    // Mismatch counting and saturation.
    for (int i = 0; i < 3; i++) begin
      push(32'h2000_0000 + 32'(i));
      xfer(1'b0, 0, 1);
    end
    chk("mis3_count", 32'(mismatch_cnt), 32'd3);
    chk("mis3_last", 32'(last_match), 32'd0);
    force dut.mis_cnt_q = 16'hFFFE;
    #1;
    release dut.mis_cnt_q;
    model_mis = 16'hFFFE;
    push(32'h3000_0000); xfer(1'b0, 0, 0);
    chk("sat_reach", 32'(mismatch_cnt), 32'h0000FFFF);
    push(32'h3000_0001); xfer(1'b0, 0, 0);
    chk("sat_hold", 32'(mismatch_cnt), 32'h0000FFFF);
    push(32'h3000_0002); xfer(1'b1, 0, 0);

    // Reset while presenting with a second word buffered.
    push(32'h4000_0000); push(32'h4000_0001);
    wait_set();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk_reset("rst_mid_set");

    // Timeout in SET: data_set held exactly TMO cycles, then ERROR until clear.
    push(32'hA5A5_0001);
    wait_set();
    for (int i = 1; i < TMO; i++) begin
      step();
      chk("tmo_set_hold", 32'(bus.data_set), 32'd1);
    end
    step();
    chk("tmo_data_set", 32'(bus.data_set), 32'd0);
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd1);
    step();
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_reset();
    chk_reset("clear");

    // cmp_irq on the timeout cycle wins; then timeout in RELEASE.
    push(32'hA5A5_0002);
    wait_set();
    for (int i = 1; i < TMO; i++) step();
    bus.cmp_irq = 1'b1; bus.cmp_match = 1'b1;
    step();
    bus.cmp_irq = 1'b0; bus.cmp_match = 1'b0;
    chk("irq_wins_err", 32'(timeout_err), 32'd0);
    chk("irq_wins_drop", 32'(bus.data_set), 32'd0);
    chk("irq_wins_match", 32'(last_match), 32'd1);
    for (int i = 1; i < TMO; i++) begin
      step();
      chk("rel_wait_err", 32'(timeout_err), 32'd0);
    end
    step();
    chk("rel_tmo_err", 32'(timeout_err), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    model_reset();
    chk_reset("clear2");

    // Randomized bursts against the queue model.
    for (int it = 0; it < 15; it++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) push($urandom());
      while (model_q.size() > 0)
        xfer(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4));
      chk("rand_busy_idle", 32'(busy), 32'd0);
    end

`ifdef FAULT_INJECT_EN
    inject_en = 1'b1;
    lfsr_mask = 32'h0000_0001;
    push(32'h0000_0010);
    wait_set();
    chk("fi_data", bus.data_out, 32'h0000_0011);
    lfsr_mask = 32'hFFFF_0000;
    step();
    chk("fi_stable", bus.data_out, 32'h0000_0011);
    bus.cmp_irq = 1'b1; bus.cmp_match = 1'b1;
    step();
    bus.cmp_irq = 1'b0; bus.cmp_ready = 1'b1;
    step();
    bus.cmp_ready = 1'b0;
    void'(model_q.pop_front());
    inject_en = 1'b0;
    chk("fi_busy", 32'(busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
